ethpipe_rx_drain: RTL and testbench



---
 rtl/ethpipe_pkg.sv | 43 ++++
 rtl/ethpipe_skid2.sv | 56 +++++
 rtl/ethpipe_rx_drain.sv | 159 +++++++++++++++
 tb/tb_ethpipe_rx_drain.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ethpipe_pkg.sv
// Shared RX/TX ethpipe definitions: drain FSM states, frame-record header layout, stream beat type.
package ethpipe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_DATA,
        ST_DONE
    } ethpipe_state_e;

    localparam logic [15:0] ETH_HDR_MAGIC = 16'hE7B1;

    localparam int HDR_MAGIC_LSB = 16;
    localparam int HDR_TRUNC_BIT = 15;
    localparam int HDR_LEN_LSB   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } ethpipe_beat_t;

    // Byte enables for the final word of a len-byte record.
    function automatic logic [3:0] keep_from_len(input logic [1:0] len_lo);
        case (len_lo)
            2'd1:    keep_from_len = 4'h1;
            2'd2:    keep_from_len = 4'h3;
            2'd3:    keep_from_len = 4'h7;
            default: keep_from_len = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] hdr0_pack(input logic [15:0] magic, input logic trunc,
                                              input logic [11:0] len);
        hdr0_pack                          = '0;
        hdr0_pack[HDR_MAGIC_LSB +: 16]     = magic;
        hdr0_pack[HDR_TRUNC_BIT]           = trunc;
        hdr0_pack[HDR_LEN_LSB +: 12]       = len;
    endfunction

endpackage

// File: rtl/ethpipe_skid2.sv
// Two-entry valid/ready buffer with registered outputs. The producer must track o_count
// itself; a push into a full buffer with no pop is discarded.
module ethpipe_skid2
    import ethpipe_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  ethpipe_beat_t i_beat,
    output logic          o_valid,
    output ethpipe_beat_t o_beat,
    input  logic          i_ready,
    output logic [1:0]    o_count
);

    ethpipe_beat_t r_buf0, r_buf1;
    logic [1:0]    r_cnt;
    logic          w_pop, w_push;

    assign w_pop  = (r_cnt != 2'd0) & i_ready;
    assign w_push = i_valid & ((r_cnt != 2'd2) | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_buf0 <= i_beat;
                    else               r_buf1 <= i_beat;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_buf0 <= i_beat;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= i_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_beat  = r_buf0;
    assign o_count = r_cnt;

endmodule

// File: rtl/ethpipe_rx_drain.sv
// Drains a received frame slot into a 32-bit header+payload stream and frees the slot.
// Build option ETHPIPE_RX_FCS_STRIP_EN removes the trailing 4 FCS bytes from the record.
module ethpipe_rx_drain
    import ethpipe_pkg::*;
#(
    parameter logic [10:0] DATA_START_ADDR = 11'd5,
    parameter logic [11:0] MAX_FRAME_LEN   = 12'd2048,
    parameter logic [15:0] HDR_MAGIC       = ETH_HDR_MAGIC
) (
    input  logic        pci_clk,
    input  logic        sys_rst_n,
    input  logic        rx_complete,
    input  logic [11:0] rx_frame_len,
    input  logic [63:0] rx_timestamp,
    output logic [10:0] slot_rd_address,
    input  logic [31:0] slot_rd_q,
    output logic        rx_empty,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] drop_count
);

    ethpipe_state_e r_state;
    logic [11:0]    r_len;
    logic           r_trunc;
    logic [63:0]    r_ts;
    logic [10:0]    r_rd_addr;
    logic [9:0]     r_words_left;
    logic           r_last_pushed;
    logic           r_rd_vld;
    logic [3:0]     r_rd_keep;
    logic           r_rd_last;
    logic           r_empty;
    logic [15:0]    r_drop;

    logic [11:0]    w_len_clamp, w_len;
    logic [9:0]     w_words;
    logic [1:0]     w_cnt;
    logic [2:0]     w_occ;
    logic           w_pop, w_room, w_in_hdr, w_hdr_push, w_rd_en, w_in_vld;
    logic [31:0]    w_hdr_word;
    ethpipe_beat_t  w_in, w_out;

    assign w_len_clamp = (rx_frame_len > MAX_FRAME_LEN) ? MAX_FRAME_LEN : rx_frame_len;
`ifdef ETHPIPE_RX_FCS_STRIP_EN
    assign w_len = (w_len_clamp < 12'd4) ? 12'd0 : (w_len_clamp - 12'd4);
`else
    assign w_len = w_len_clamp;
`endif
    assign w_words = w_len[11:2] + {9'd0, |w_len[1:0]};

    // Reserve a buffer slot for every word in flight, so the RAM's one-cycle read latency
    // never lands data on a full buffer even if m_ready drops.
    assign w_pop      = m_valid & m_ready;
    assign w_occ      = {1'b0, w_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
    assign w_room     = (w_occ < 3'd2);
    assign w_in_hdr   = (r_state == ST_HDR0) | (r_state == ST_HDR1) | (r_state == ST_HDR2);
    assign w_hdr_push = w_in_hdr & w_room & ~r_last_pushed;
    assign w_rd_en    = (r_state == ST_DATA) & (r_words_left != 10'd0) & w_room;

    always_comb begin
        w_hdr_word = r_ts[31:0];
        case (r_state)
            ST_HDR0: w_hdr_word = hdr0_pack(HDR_MAGIC, r_trunc, r_len);
            ST_HDR1: w_hdr_word = r_ts[63:32];
            default: ;
        endcase
    end

    always_comb begin
        w_in_vld = r_rd_vld | w_hdr_push;
        w_in     = '{data: w_hdr_word, keep: 4'hF,
                     last: (r_state == ST_HDR2) && (r_len == 12'd0)};
        if (r_rd_vld)
            w_in = '{data: slot_rd_q, keep: r_rd_keep, last: r_rd_last};
    end

    always_ff @(posedge pci_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_trunc       <= 1'b0;
            r_ts          <= '0;
            r_rd_addr     <= '0;
            r_words_left  <= '0;
            r_last_pushed <= 1'b0;
            r_rd_vld      <= 1'b0;
            r_rd_keep     <= '0;
            r_rd_last     <= 1'b0;
            r_empty       <= 1'b1;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en) begin
                r_rd_addr    <= r_rd_addr + 11'd1;
                r_words_left <= r_words_left - 10'd1;
                r_rd_last    <= (r_words_left == 10'd1);
                r_rd_keep    <= (r_words_left == 10'd1) ? keep_from_len(r_len[1:0]) : 4'hF;
            end
            case (r_state)
                ST_IDLE: if (rx_complete) begin
                    r_len        <= w_len;
                    r_trunc      <= (rx_frame_len > MAX_FRAME_LEN);
                    r_ts         <= rx_timestamp;
                    r_rd_addr    <= DATA_START_ADDR;
                    r_words_left <= w_words;
                    r_empty      <= 1'b0;
                    r_state      <= ST_HDR0;
                end
                ST_HDR0: if (w_hdr_push) r_state <= ST_HDR1;
                ST_HDR1: if (w_hdr_push) r_state <= ST_HDR2;
                // A zero-length record ends on HDR2, so wait here for its handshake.
                ST_HDR2: begin
                    if (w_pop && m_last)
                        r_state <= ST_DONE;
                    else if (w_hdr_push) begin
                        if (r_len == 12'd0) r_last_pushed <= 1'b1;
                        else                r_state       <= ST_DATA;
                    end
                end
                ST_DATA: if (w_pop && m_last) r_state <= ST_DONE;
                ST_DONE: begin
                    r_empty       <= 1'b1;
                    r_last_pushed <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pci_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_drop <= '0;
        else if (rx_complete && (r_state != ST_IDLE) && (r_drop != 16'hFFFF))
            r_drop <= r_drop + 16'd1;
    end

    ethpipe_skid2 u_skid (
        .i_clk   (pci_clk),
        .i_rst_n (sys_rst_n),
        .i_valid (w_in_vld),
        .i_beat  (w_in),
        .o_valid (m_valid),
        .o_beat  (w_out),
        .i_ready (m_ready),
        .o_count (w_cnt)
    );

    assign m_data          = w_out.data;
    assign m_keep          = w_out.keep;
    assign m_last          = w_out.last;
    assign slot_rd_address = r_rd_addr;
    assign rx_empty        = r_empty;
    assign drop_count      = r_drop;

endmodule

// File: tb/tb_ethpipe_rx_drain.sv
// Directed bench for ethpipe_rx_drain: slot RAM model, beat collector, hand-derived expectations.
module tb_ethpipe_rx_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_complete = 1'b0;
    logic [11:0] rx_frame_len = '0;
    logic [63:0] rx_timestamp = '0;
    logic [10:0] slot_rd_address;
    logic [31:0] slot_rd_q = '0;
    logic        rx_empty;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last, m_valid;
    logic        m_ready;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_cnt = 0;
    int last_cyc = 0;
    int rise_cyc = 0;
    logic prev_empty = 1'b0;
    bit tog_en = 1'b0;
    logic [31:0] hdr0_seen;
    int nbeats_seen;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;
    beat_t beats[$];

    logic [31:0] mem [2048];

    ethpipe_rx_drain dut (
        .pci_clk         (clk),
        .sys_rst_n       (rst_n),
        .rx_complete     (rx_complete),
        .rx_frame_len    (rx_frame_len),
        .rx_timestamp    (rx_timestamp),
        .slot_rd_address (slot_rd_address),
        .slot_rd_q       (slot_rd_q),
        .rx_empty        (rx_empty),
        .m_data          (m_data),
        .m_keep          (m_keep),
        .m_last          (m_last),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        slot_rd_q <= mem[slot_rd_address];
    end

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            beats.push_back('{d: m_data, k: m_keep, l: m_last});
            if (m_last) begin
                last_cnt <= last_cnt + 1;
                last_cyc <= cyc;
            end
        end
        if (rx_empty && !prev_empty) rise_cyc <= cyc;
        prev_empty <= rx_empty;
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) m_ready = ~m_ready;
            else        m_ready = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_len(input int f);
        int c;
        c = (f > 2048) ? 2048 : f;
`ifdef ETHPIPE_RX_FCS_STRIP_EN
        c = (c < 4) ? 0 : c - 4;
`endif
        return c;
    endfunction

    function automatic logic [3:0] model_keep(input int len);
        case (len % 4)
            1:       return 4'h1;
            2:       return 4'h3;
            3:       return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

    task automatic send_pulse(input logic [11:0] flen, input logic [63:0] ts);
        @(posedge clk);
        #1;
        rx_frame_len = flen;
        rx_timestamp = ts;
        rx_complete  = 1'b1;
        @(posedge clk);
        #1;
        rx_complete  = 1'b0;
    endtask

    task automatic run_frame(input string nm, input int flen, input logic [63:0] ts,
                             input bit toggle, input int drop_at);
        int elen, words, base, lc0, n;
        logic trunc;
        logic [31:0] exp_hdr0;
        elen  = model_len(flen);
        trunc = (flen > 2048);
        words = (elen + 3) / 4;
        base  = beats.size();
        lc0   = last_cnt;
        exp_hdr0 = {16'hE7B1, trunc, 3'b000, 12'(elen)};
        tog_en = toggle;
        send_pulse(12'(flen), ts);
        chk({nm, "_busy"}, rx_empty, 1'b0);
        @(negedge clk);
        chk({nm, "_lat1"}, m_valid, 1'b0);
        @(negedge clk);
        chk({nm, "_lat2"}, m_valid, 1'b1);
        for (n = 0; n < 5000 && !(last_cnt > lc0 && rx_empty); n++) begin
            @(posedge clk);
            #1;
            rx_complete = (n == drop_at);
        end
        rx_complete = 1'b0;
        @(negedge clk);
        #1;
        tog_en = 1'b0;
        chk({nm, "_done"}, (last_cnt == lc0 + 1) && rx_empty, 1'b1);
        nbeats_seen = beats.size() - base;
        hdr0_seen   = (nbeats_seen > 0) ? beats[base].d : 32'h0;
        chk({nm, "_nbeats"}, nbeats_seen, 3 + words);
        if (nbeats_seen >= 3) begin
            chk({nm, "_hdr0"}, beats[base].d, exp_hdr0);
            chk({nm, "_hdr1"}, beats[base+1].d, ts[63:32]);
            chk({nm, "_hdr2"}, beats[base+2].d, ts[31:0]);
            chk({nm, "_hdr2_last"}, beats[base+2].l, words == 0);
            chk({nm, "_hdr_keep"}, {beats[base].k, beats[base+1].k, beats[base+2].k}, 12'hFFF);
        end
        for (int k = 0; k < words && 3 + k < nbeats_seen; k++) begin
            chk($sformatf("%s_d%0d", nm, k), beats[base+3+k].d, mem[(5 + k) % 2048]);
            chk($sformatf("%s_k%0d", nm, k), beats[base+3+k].k,
                (k == words - 1) ? model_keep(elen) : 4'hF);
            chk($sformatf("%s_l%0d", nm, k), beats[base+3+k].l, k == words - 1);
        end
        chk({nm, "_empty_lat"}, rise_cyc - last_cyc, 2);
        chk({nm, "_addr_end"}, slot_rd_address, (5 + words) % 2048);
    endtask

    initial begin
        int base, lc0;
        for (int i = 0; i < 2048; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", rx_empty, 1'b1);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_last", m_last, 1'b0);
        chk("rst_keep", m_keep, 4'h0);
        chk("rst_data", m_data, 32'h0);
        chk("rst_addr", slot_rd_address, 11'h0);
        chk("rst_drop", drop_count, 16'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame("t1", 64, 64'h0123_4567_89AB_CDEF, 1'b0, -1);

        run_frame("t2", 61, 64'h1111_2222_3333_4444, 1'b0, -1);
`ifdef ETHPIPE_RX_FCS_STRIP_EN
        chk("t2_hdr0_hand", hdr0_seen, 32'hE7B1_0039);
        chk("t2_beats_hand", nbeats_seen, 18);
`else
        chk("t2_hdr0_hand", hdr0_seen, 32'hE7B1_003D);
        chk("t2_beats_hand", nbeats_seen, 19);
`endif

        run_frame("t3", 64, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, -1);

        run_frame("t4", 3000, 64'hCAFE_0000_0000_0001, 1'b0, 20);
`ifdef ETHPIPE_RX_FCS_STRIP_EN
        chk("t4_hdr0_hand", hdr0_seen, 32'hE7B1_87FC);
`else
        chk("t4_hdr0_hand", hdr0_seen, 32'hE7B1_8800);
        chk("t4_beats_hand", nbeats_seen, 515);
`endif
        chk("t4_drop", drop_count, 16'd1);

        run_frame("t5", 0, 64'h0000_0005_0000_0005, 1'b0, -1);

        base = beats.size();
        lc0  = last_cnt;
        send_pulse(12'd64, 64'h6666_7777_8888_9999);
        for (int n = 0; n < 200 && beats.size() < base + 8; n++) begin
            @(negedge clk);
            #1;
        end
        chk("t6_pre_beats", beats.size() - base, 8);
        if (beats.size() >= base + 8) chk("t6_word4", beats[base+7].d, mem[9]);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid", m_valid, 1'b0);
        chk("t6_empty", rx_empty, 1'b1);
        chk("t6_no_last", last_cnt, lc0);
        chk("t6_drop_clr", drop_count, 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_frame("t6b", 61, 64'hABCD_0123_4567_89EF, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
